// File: rtl/aes_out_scheduler.sv
// Output scheduler for the AES controller: round-robin merges the cipher and
// pass-through block streams into the output FIFO, one command of N blocks at a time.
module aes_out_scheduler #(
  parameter int FIFO_DATA_WIDTH = 128,
  parameter int BLK_CNT_WIDTH   = 16
) (
  input  logic                       m00_axis_aclk,
  input  logic                       m00_axis_aresetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [BLK_CNT_WIDTH-1:0]   cmd_blk_cnt,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [FIFO_DATA_WIDTH-1:0] req0_data,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [FIFO_DATA_WIDTH-1:0] req1_data,
  output logic                       out_fifo_write_tvalid,
  output logic [FIFO_DATA_WIDTH-1:0] aes_controller_out_fifo_data,
  input  logic                       out_fifo_write_tready,
  input  logic                       out_fifo_almost_full,
  output logic                       processing_done,
  input  logic                       axis_master_done,
  output logic                       busy,
  output logic                       cmd_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state;
  logic [BLK_CNT_WIDTH-1:0]   remaining;
  logic [FIFO_DATA_WIDTH-1:0] out_data;
  logic                       out_valid;
  logic                       last_grant;
  logic                       transfer;
  logic                       can_grant;
  logic                       grant0;
  logic                       grant1;

  assign transfer  = out_valid & out_fifo_write_tready;
  assign can_grant = (state == RUN) && (remaining != '0) && !out_fifo_almost_full &&
                     (!out_valid || out_fifo_write_tready);

  // last_grant=1 means req1 was served last, so req0 wins the next tie
  assign grant0 = can_grant && req0_valid && (!req1_valid || last_grant);
  assign grant1 = can_grant && req1_valid && (!req0_valid || !last_grant);

  assign req0_ready                   = grant0;
  assign req1_ready                   = grant1;
  assign out_fifo_write_tvalid        = out_valid;
  assign aes_controller_out_fifo_data = out_data;
  assign busy                         = (state != IDLE);
  // Gated by reset so no command is offered while the block is held in reset
  assign cmd_ready                    = (state == IDLE) && m00_axis_aresetn;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state           <= IDLE;
      remaining       <= '0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      last_grant      <= 1'b1;
      processing_done <= 1'b0;
      cmd_err         <= 1'b0;
    end else begin
      cmd_err <= 1'b0;

      if (grant0 || grant1) begin
        out_valid  <= 1'b1;
        out_data   <= grant0 ? req0_data : req1_data;
        remaining  <= remaining - BLK_CNT_WIDTH'(1);
        last_grant <= grant1;
      end else if (transfer) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_blk_cnt == '0) begin
              cmd_err <= 1'b1;
            end else begin
              remaining <= cmd_blk_cnt;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if ((remaining == '0) && transfer) begin
            state           <= DONE;
            processing_done <= 1'b1;
          end
        end
        DONE: begin
          if (axis_master_done) begin
            state           <= IDLE;
            processing_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_out_scheduler.md
AES_OUT_SCHEDULER -- requirements
Module: aes_out_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DATA_WIDTH, default 128: width of one AES block and of the output FIFO word.
REQ-002 SHALL have parameter BLK_CNT_WIDTH, default 16: width of the per-command block count.
REQ-003 SHALL have port m00_axis_aclk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port m00_axis_aresetn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1) and cmd_blk_cnt (in, BLK_CNT_WIDTH): the command handshake; cmd_blk_cnt is the number of blocks in the command.
REQ-006 SHALL have ports req0_valid (in, 1), req0_ready (out, 1) and req0_data (in, FIFO_DATA_WIDTH): the cipher engine result block.
REQ-007 SHALL have ports req1_valid (in, 1), req1_ready (out, 1) and req1_data (in, FIFO_DATA_WIDTH): the pass-through/IV echo block.
REQ-008 SHALL have ports out_fifo_write_tvalid (out, 1), aes_controller_out_fifo_data (out, FIFO_DATA_WIDTH), out_fifo_write_tready (in, 1) and out_fifo_almost_full (in, 1): the output FIFO write port.
REQ-009 SHALL have ports processing_done (out, 1) and axis_master_done (in, 1 pulse): end-of-command signalling with the stream master.
REQ-010 SHALL have ports busy (out, 1) and cmd_err (out, 1 pulse): status outputs.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE; busy SHALL be high whenever the state is not IDLE.
REQ-012 In IDLE, cmd_ready SHALL be 1; in all other states it SHALL be 0.
REQ-013 In IDLE, a cmd handshake with cmd_blk_cnt=0 SHALL pulse cmd_err for 1 cycle and the FSM SHALL stay in IDLE.
REQ-014 In IDLE, a cmd handshake with cmd_blk_cnt>0 SHALL load the remaining counter with cmd_blk_cnt and move the FSM to RUN.
REQ-015 The block output stage SHALL be one register: out_fifo_write_tvalid is high while it holds a block; a transfer occurs on tvalid && tready.
REQ-016 A grant SHALL be issued only when all of the following hold:
- the state is RUN;
- remaining>0;
- out_fifo_almost_full=0;
- the output register is empty or transfers in the same cycle.
REQ-017 reqN_ready SHALL equal the grant to requester N; it SHALL be 0 in IDLE and DONE; it SHALL never depend on the other port's ready.
REQ-018 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not granted last. A last-grant register SHALL reset to 1, so req0 wins the first tie. A single valid requester SHALL always be granted.
REQ-019 On a grant, the selected data SHALL load into the output register, with out_fifo_write_tvalid=1 in the next cycle (1-cycle latency). remaining SHALL decrement by 1.
REQ-020 The output block SHALL be held stable while tvalid=1 and tready=0.
REQ-021 A transfer and a grant in the same cycle SHALL give back-to-back blocks with no bubble (1 block/cycle sustained).
REQ-022 When remaining=0 and the output register transfers its last block, the FSM SHALL move RUN->DONE. processing_done SHALL rise in the cycle after the last FIFO write is accepted, never earlier.
REQ-023 In DONE, processing_done SHALL stay 1 until axis_master_done=1; the FSM SHALL then move to IDLE, with processing_done=0 in the following cycle.
REQ-024 axis_master_done outside DONE SHALL be ignored.
REQ-025 Requester blocks beyond cmd_blk_cnt SHALL NOT be accepted (ready stays 0).
REQ-026 The remaining counter SHALL be unsigned BLK_CNT_WIDTH bits and SHALL never decrement below 0. A maximum count of 2^BLK_CNT_WIDTH-1 SHALL complete correctly.

Reset
REQ-027 Asynchronous assertion of m00_axis_aresetn=0 SHALL immediately force all of the following:
- state IDLE;
- remaining=0;
- output register empty;
- out_fifo_write_tvalid=0;
- processing_done=0;
- busy=0;
- cmd_err=0;
- req0_ready=0 and req1_ready=0;
- last-grant=1.
REQ-028 cmd_ready SHALL be 0 during reset; reset SHALL be released synchronously at the source.
REQ-029 Reset mid-command SHALL discard the in-flight block without a write. A new command after deassertion SHALL behave as from power-up.

Verification
REQ-030 Single source: cmd_blk_cnt=3 with req0 always valid and tready=1 -> 3 consecutive writes, processing_done high one cycle after the 3rd accept, then low after an axis_master_done pulse.
REQ-031 Contention: cmd_blk_cnt=4 with req0 and req1 both valid -> write order req0, req1, req0, req1, and neither ready is asserted after the 4th grant.
REQ-032 Backpressure: tready=0 for 5 cycles with a block held -> data and tvalid stay stable, no grant occurs, and the block is written once tready=1.
REQ-033 Throttle: out_fifo_almost_full=1 -> no new grant while the pending block still drains; grants resume the cycle after almost_full=0.
REQ-034 Errors/reset: cmd_blk_cnt=0 -> cmd_err pulse, FSM stays IDLE. Aresetn=0 after 2 of 8 blocks -> tvalid=0 and busy=0 immediately, and a fresh 2-block command then completes normally.
